// File: rtl/alu_sched_pkg.sv
// rtl/alu_sched_pkg.sv - op codes, ALU control words and FSM states for alu_req_scheduler
package alu_sched_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_NOR = 3'b101;

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_NOR = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] ctl;
    logic       cin;
    logic       illegal;
  } dec_t;

  // SLT reuses the SUB control word; the less-than bit is derived from the difference.
  function automatic dec_t decode_op(input logic [2:0] op);
    dec_t d;
    d = '{ctl: CTL_AND, cin: 1'b0, illegal: 1'b0};
    case (op)
      OP_AND: d.ctl = CTL_AND;
      OP_OR:  d.ctl = CTL_OR;
      OP_ADD: d.ctl = CTL_ADD;
      OP_SUB: begin d.ctl = CTL_SUB; d.cin = 1'b1; end
      OP_SLT: begin d.ctl = CTL_SUB; d.cin = 1'b1; end
      OP_NOR: d.ctl = CTL_NOR;
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu64.sv
// rtl/alu64.sv - 64-bit ALU: optional operand inversion, and/or/add select, carry in/out
module alu64 (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic [3:0]  ctl,
  input  logic        cin,
  output logic [63:0] result,
  output logic        cout,
  output logic        overflow
);

  logic [63:0] aa;
  logic [63:0] bb;
  logic [64:0] sum;

  assign aa       = ctl[3] ? ~a : a;
  assign bb       = ctl[2] ? ~b : b;
  assign sum      = {1'b0, aa} + {1'b0, bb} + {64'd0, cin};
  assign cout     = sum[64];
  assign overflow = (aa[63] == bb[63]) && (sum[63] != aa[63]);

  always_comb begin
    result = '0;
    case (ctl[1:0])
      2'b00: result = aa & bb;
      2'b01: result = aa | bb;
      2'b10: result = sum[63:0];
      default: result = {63'd0, sum[63] ^ overflow};
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick of the first request at or above the pointer
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  always_comb begin
    int j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_req_scheduler.sv
// rtl/alu_req_scheduler.sv - shares one alu64 among NREQ requesters with a single response port
module alu_req_scheduler
  import alu_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [3*NREQ-1:0]  req_op,
  input  logic [64*NREQ-1:0] req_a,
  input  logic [64*NREQ-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [63:0]        rsp_result,
  output logic               rsp_zero,
  output logic               rsp_cout,
  output logic               rsp_ovf,
  output logic               rsp_err
);

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            grant_any;

  logic [2:0]      cap_op;
  logic [63:0]     cap_a;
  logic [63:0]     cap_b;
  logic [IDW-1:0]  cap_id;

  dec_t            dec;
  logic [63:0]     alu_res;
  logic            alu_cout;
  logic            unused_alu_ovf;

  logic [63:0]     nxt_result;
  logic            nxt_cout;
  logic            nxt_ovf;
  logic            nxt_err;
  logic            slt_lt;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  // Gated by rst_n so nothing looks accepted on an edge that reset will discard.
  assign req_ready = (state == ST_IDLE && rst_n) ? grant : '0;

  assign dec = decode_op(cap_op);

  alu64 u_alu (
    .a        (cap_a),
    .b        (cap_b),
    .ctl      (dec.ctl),
    .cin      (dec.cin),
    .result   (alu_res),
    .cout     (alu_cout),
    .overflow (unused_alu_ovf)
  );

  assign slt_lt = (cap_a[63] != cap_b[63]) ? cap_a[63] : alu_res[63];

  always_comb begin
    nxt_result = '0;
    nxt_cout   = 1'b0;
    nxt_ovf    = 1'b0;
    nxt_err    = 1'b0;
    case (cap_op)
      OP_AND, OP_OR, OP_NOR: nxt_result = alu_res;
      OP_ADD: begin
        nxt_result = alu_res;
        nxt_cout   = alu_cout;
        nxt_ovf    = (cap_a[63] == cap_b[63]) && (alu_res[63] != cap_a[63]);
      end
      OP_SUB: begin
        nxt_result = alu_res;
        nxt_cout   = alu_cout;
        nxt_ovf    = (cap_a[63] != cap_b[63]) && (alu_res[63] != cap_a[63]);
      end
      OP_SLT: nxt_result = {63'd0, slt_lt};
      default: nxt_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      cap_op     <= '0;
      cap_a      <= '0;
      cap_b      <= '0;
      cap_id     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_cout   <= 1'b0;
      rsp_ovf    <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            cap_op <= req_op[int'(grant_idx)*3 +: 3];
            cap_a  <= req_a[int'(grant_idx)*64 +: 64];
            cap_b  <= req_b[int'(grant_idx)*64 +: 64];
            cap_id <= grant_idx;
            ptr    <= (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + IDW'(1);
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_valid  <= 1'b1;
          rsp_id     <= cap_id;
          rsp_result <= nxt_result;
          rsp_zero   <= (nxt_result == 64'd0);
          rsp_cout   <= nxt_cout;
          rsp_ovf    <= nxt_ovf;
          rsp_err    <= nxt_err;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_scheduler.sv
// tb/tb_alu_req_scheduler.sv - directed and randomized self-checking bench for alu_req_scheduler
module tb_alu_req_scheduler;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [63:0]    result;
    logic           zero;
    logic           cout;
    logic           ovf;
    logic           err;
  } rsp_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    req_ready;
  logic [3*NREQ-1:0]  req_op = '0;
  logic [64*NREQ-1:0] req_a = '0;
  logic [64*NREQ-1:0] req_b = '0;
  logic               rsp_valid;
  logic               rsp_ready = 1'b0;
  logic [IDW-1:0]     rsp_id;
  logic [63:0]        rsp_result;
  logic               rsp_zero;
  logic               rsp_cout;
  logic               rsp_ovf;
  logic               rsp_err;

  int checks = 0;
  int errors = 0;

  alu_req_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_cout   (rsp_cout),
    .rsp_ovf    (rsp_ovf),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] flags(input rsp_t r);
    return {r.id, r.zero, r.cout, r.ovf, r.err};
  endfunction

  function automatic rsp_t observed();
    return {rsp_id, rsp_result, rsp_zero, rsp_cout, rsp_ovf, rsp_err};
  endfunction

  // Reference computed with wide signed/unsigned arithmetic straight from the op definitions.
  function automatic rsp_t ref_model(input logic [IDW-1:0] id, input logic [2:0] op,
                                     input logic [63:0] a, input logic [63:0] b);
    rsp_t r;
    logic [64:0] w;
    logic signed [64:0] s;
    r = '0;
    r.id = id;
    case (op)
      3'd0: r.result = a & b;
      3'd1: r.result = a | b;
      3'd2: begin
        w = {1'b0, a} + {1'b0, b};
        r.result = w[63:0];
        r.cout = w[64];
        s = $signed({a[63], a}) + $signed({b[63], b});
        r.ovf = (s[64] != s[63]);
      end
      3'd3: begin
        r.result = a - b;
        r.cout = (a >= b);
        s = $signed({a[63], a}) - $signed({b[63], b});
        r.ovf = (s[64] != s[63]);
      end
      3'd4: r.result = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      3'd5: r.result = ~(a | b);
      default: r.err = 1'b1;
    endcase
    r.zero = (r.result == 64'd0);
    return r;
  endfunction

  function automatic logic [63:0] pick();
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0: v = 64'd0;
      1: v = 64'h7FFF_FFFF_FFFF_FFFF;
      2: v = 64'h8000_0000_0000_0000;
      3: v = '1;
      4: v = 64'd1;
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Entered and left 1 time unit after a rising edge.
  task automatic single(input int id, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, output rsp_t r);
    int n;
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[id] = 1'b1;
    rsp_ready = 1'b0;
    req_valid = '0;
    req_valid[id] = 1'b1;
    req_op[id*3 +: 3] = op;
    req_a[id*64 +: 64] = a;
    req_b[id*64 +: 64] = b;
    n = 0;
    #1;
    while (req_ready !== oh && n < 10) begin
      step();
      #1;
      n++;
    end
    chk("grant", 64'(req_ready), 64'(oh));
    step();
    req_valid[id] = 1'b0;
    #1;
    chk("exec_no_rsp", 64'(rsp_valid), 64'd0);
    step();
    #1;
    chk("rsp_latency", 64'(rsp_valid), 64'd1);
    r = observed();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  rsp_t r;
  rsp_t held;
  rsp_t exp_q[$];
  int   due_q[$];

  initial begin
    int n;
    int got;
    int ptr;
    int gidx;
    logic [NREQ-1:0] exp_ready;
    logic exp_v;

    do_reset();
    #1;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    chk("reset_rsp_result", rsp_result, 64'd0);
    step();

    single(0, 3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, r);
    chk("add_result", r.result, 64'h8000_0000_0000_0000);
    chk("add_flags", 64'(flags(r)), 64'(6'b00_0010));

    single(1, 3'b011, 64'd5, 64'd5, r);
    chk("sub_result", r.result, 64'd0);
    chk("sub_flags", 64'(flags(r)), 64'(6'b01_1100));

    single(1, 3'b100, '1, 64'd1, r);
    chk("slt_neg_result", r.result, 64'd1);
    chk("slt_neg_flags", 64'(flags(r)), 64'(6'b01_0000));

    single(1, 3'b100, 64'd1, '1, r);
    chk("slt_pos_result", r.result, 64'd0);
    chk("slt_pos_flags", 64'(flags(r)), 64'(6'b01_1000));

    single(2, 3'b110, 64'd9, 64'd3, r);
    chk("illegal_result", r.result, 64'd0);
    chk("illegal_flags", 64'(flags(r)), 64'(6'b10_1001));

    // Reset while the operation is in EXEC: it must vanish.
    req_valid[3] = 1'b1;
    req_op[9 +: 3] = 3'b010;
    req_a[192 +: 64] = 64'd4;
    req_b[192 +: 64] = 64'd4;
    #1;
    chk("exec_rst_grant", 64'(req_ready), 64'(4'b1000));
    step();
    req_valid = '0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("exec_rst_no_rsp", 64'(rsp_valid), 64'd0);
      step();
    end

    // Reset while a response waits; pointer must return to requester 0.
    req_valid[2] = 1'b1;
    req_op[6 +: 3] = 3'b000;
    #1;
    chk("resp_rst_grant", 64'(req_ready), 64'(4'b0100));
    step();
    req_valid = '0;
    step();
    #1;
    chk("resp_rst_pending", 64'(rsp_valid), 64'd1);
    step();
    rst_n = 1'b0;
    req_valid = 4'b0101;
    step();
    #1;
    chk("in_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("in_rst_req_ready", 64'(req_ready), 64'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("post_rst_grant", 64'(req_ready), 64'(4'b0001));

    // Response backpressure: held outputs, no grants until accepted.
    do_reset();
    req_valid[1] = 1'b1;
    req_op[3 +: 3] = 3'b000;
    req_a[64 +: 64] = 64'hF0F0_F0F0_1234_5678;
    req_b[64 +: 64] = 64'hFF00_FF00_FFFF_0000;
    step();
    req_valid = '0;
    step();
    step();
    #1;
    held = observed();
    chk("hold_first", held.result, 64'hF000_F000_1234_0000);
    req_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      #1;
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_rsp", 64'(observed()), 64'(held));
      chk("hold_req_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    #1;
    chk("resume_grant", 64'(req_ready), 64'(4'b0001));

    // All requesters busy: strict rotation.
    do_reset();
    req_valid = '1;
    req_op = '0;
    rsp_ready = 1'b1;
    n = 0;
    got = 0;
    while (got < 6 && n < 60) begin
      #1;
      if (rsp_valid) begin
        chk("rr_id", 64'(rsp_id), 64'(got % NREQ));
        got++;
      end
      step();
      n++;
    end
    chk("rr_count", 64'(got), 64'd6);

    // Randomized traffic against a queue-based model.
    do_reset();
    ptr = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          req_op[i*3 +: 3] = 3'($urandom_range(0, 7));
          req_a[i*64 +: 64] = pick();
          req_b[i*64 +: 64] = pick();
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_ready = '0;
      gidx = -1;
      if (exp_q.size() == 0) begin
        for (int k = 0; k < NREQ; k++) begin
          if (gidx < 0 && req_valid[(ptr + k) % NREQ]) gidx = (ptr + k) % NREQ;
        end
      end
      if (gidx >= 0) exp_ready[gidx] = 1'b1;
      chk("rnd_req_ready", 64'(req_ready), 64'(exp_ready));
      exp_v = (exp_q.size() > 0) && (c >= due_q[0]);
      chk("rnd_rsp_valid", 64'(rsp_valid), 64'(exp_v));
      if (exp_v && rsp_valid) begin
        chk("rnd_result", rsp_result, exp_q[0].result);
        chk("rnd_flags", 64'(flags(observed())), 64'(flags(exp_q[0])));
        if (rsp_ready) begin
          void'(exp_q.pop_front());
          void'(due_q.pop_front());
        end
      end
      if (gidx >= 0) begin
        exp_q.push_back(ref_model(IDW'(gidx), req_op[gidx*3 +: 3],
                                  req_a[gidx*64 +: 64], req_b[gidx*64 +: 64]));
        due_q.push_back(c + 2);
        ptr = (gidx + 1) % NREQ;
      end
      step();
      if (gidx >= 0) req_valid[gidx] = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
